// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder: input valid/ready with operands, output
// valid/ready with result flags.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is processed CHUNK bits per clock,
// least-significant chunk first, with the carry registered between chunks.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned SafeChunk = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned NCHUNK    = WIDTH / SafeChunk;
  localparam int unsigned IdxW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  if ((CHUNK == 0) || ((WIDTH % SafeChunk) != 0)) begin : g_cfg_err
    $error("seq_chunk_adder: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // b already inverted for subtract
  logic [WIDTH-1:0] r_q, r_d;       // partial result, filled chunk by chunk
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic [31:0]      lsb;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] r_chunk;
  logic             c_next;
  logic [WIDTH-1:0] r_next;

  // Chunk datapath for the current index.
  always_comb begin
    lsb     = 32'(idx_q) * CHUNK;
    a_chunk = CHUNK'(a_q >> lsb);
    b_chunk = CHUNK'(b_q >> lsb);
    {c_next, r_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    r_next  = r_q | (WIDTH'(r_chunk) << lsb);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ^ bus.cin;
          sub_d   = bus.sub;
          r_d     = '0;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        carry_d = c_next;
        r_d     = r_next;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
          sum_d   = r_next;
          // Subtract reports borrow, the inverse of the final carry.
          cout_d  = sub_q ? ~c_next : c_next;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_next[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder at (16,4), (8,8) and (32,1); directed cases plus a random
// regression against an arithmetic reference model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] drv_a, drv_b;
  logic        drv_cin, drv_sub, drv_in_valid, drv_out_ready;
  int unsigned sel;
  int          checks, errors;

  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
  seq_chunk_adder_if #(.WIDTH(8))  bus8 ();
  seq_chunk_adder_if #(.WIDTH(32)) bus32 ();

  assign bus16.in_valid  = drv_in_valid && (sel == 0);
  assign bus16.out_ready = drv_out_ready && (sel == 0);
  assign bus16.a         = drv_a[15:0];
  assign bus16.b         = drv_b[15:0];
  assign bus16.cin       = drv_cin;
  assign bus16.sub       = drv_sub;

  assign bus8.in_valid   = drv_in_valid && (sel == 1);
  assign bus8.out_ready  = drv_out_ready && (sel == 1);
  assign bus8.a          = drv_a[7:0];
  assign bus8.b          = drv_b[7:0];
  assign bus8.cin        = drv_cin;
  assign bus8.sub        = drv_sub;

  assign bus32.in_valid  = drv_in_valid && (sel == 2);
  assign bus32.out_ready = drv_out_ready && (sel == 2);
  assign bus32.a         = drv_a;
  assign bus32.b         = drv_b;
  assign bus32.cin       = drv_cin;
  assign bus32.sub       = drv_sub;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  logic        obs_in_ready, obs_out_valid, obs_cout, obs_ovf;
  logic [31:0] obs_sum;

  always_comb begin
    obs_in_ready  = bus16.in_ready;
    obs_out_valid = bus16.out_valid;
    obs_sum       = 32'(bus16.sum);
    obs_cout      = bus16.cout;
    obs_ovf       = bus16.ovf;
    case (sel)
      1: begin
        obs_in_ready  = bus8.in_ready;
        obs_out_valid = bus8.out_valid;
        obs_sum       = 32'(bus8.sum);
        obs_cout      = bus8.cout;
        obs_ovf       = bus8.ovf;
      end
      2: begin
        obs_in_ready  = bus32.in_ready;
        obs_out_valid = bus32.out_valid;
        obs_sum       = bus32.sum;
        obs_cout      = bus32.cout;
        obs_ovf       = bus32.ovf;
      end
      default: ;
    endcase
  end

  function automatic int unsigned width_of(input int unsigned s);
    case (s)
      1:       return 8;
      2:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int unsigned nchunk_of(input int unsigned s);
    case (s)
      1:       return 8 / 8;
      2:       return 32 / 1;
      default: return 16 / 4;
    endcase
  endfunction

  // Reference: {ovf, cout, sum} from exact arithmetic in 64 bits.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sub);
    logic [63:0] mask, av, bv, full, s;
    logic        co, am, bm, sm;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, b} & mask;
    if (!sub) begin
      full = av + bv + 64'(cin);
      s    = full & mask;
      co   = full[w];
    end else begin
      s  = (av - bv - 64'(cin)) & mask;
      co = (av < (bv + 64'(cin)));
    end
    am = av[w-1];
    bm = sub ? ~bv[w-1] : bv[w-1];
    sm = s[w-1];
    return {(am == bm) && (sm != am), co, s[31:0]};
  endfunction

  task automatic scramble(input bit junk);
    drv_a        = $urandom;
    drv_b        = $urandom;
    drv_cin      = 1'($urandom);
    drv_sub      = 1'($urandom);
    drv_in_valid = junk ? 1'($urandom) : 1'b0;
  endtask

  // Starts and ends at a falling edge with the selected DUT idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [33:0] exp, input int stall,
                        input bit junk, input string name);
    int          lat;
    int unsigned n;
    n = nchunk_of(sel);
    checks++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b out_valid=%b, required 1/0", name, obs_in_ready,
               obs_out_valid);
    end
    drv_a = a; drv_b = b; drv_cin = cin; drv_sub = sub;
    drv_in_valid  = 1'b1;
    drv_out_ready = 1'b0;
    @(negedge clk);
    drv_in_valid = 1'b0;
    scramble(junk);
    lat = 0;
    while (obs_out_valid !== 1'b1 && lat <= int'(n) + 4) begin
      @(negedge clk);
      lat++;
      scramble(junk);
    end
    checks++;
    if (lat != int'(n)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, n);
    end
    checks++;
    if ({obs_ovf, obs_cout, obs_sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got ovf,cout,sum=%h, required %h", name,
               {obs_ovf, obs_cout, obs_sum}, exp);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      scramble(junk);
      checks++;
      if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0 ||
          {obs_ovf, obs_cout, obs_sum} !== exp) begin
        errors++;
        $display("FAIL %s stall%0d: got v=%b r=%b res=%h, required v=1 r=0 res=%h", name, i,
                 obs_out_valid, obs_in_ready, {obs_ovf, obs_cout, obs_sum}, exp);
      end
    end
    drv_out_ready = 1'b1;
    @(negedge clk);
    drv_out_ready = 1'b0;
    drv_in_valid  = 1'b0;
    checks++;
    if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 ||
        {obs_ovf, obs_cout, obs_sum} !== exp) begin
      errors++;
      $display("FAIL %s release: got v=%b r=%b res=%h, required v=0 r=1 res=%h", name,
               obs_out_valid, obs_in_ready, {obs_ovf, obs_cout, obs_sum}, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_sum !== 32'd0 ||
          obs_cout !== 1'b0 || obs_ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_w%0d: got r=%b v=%b sum=%h c=%b o=%b, required 1 0 0 0 0",
                 width_of(s), obs_in_ready, obs_out_valid, obs_sum, obs_cout, obs_ovf);
      end
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    sel = 0;
    run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000}, 0, 1'b0, "add_wrap");
    run_op(32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000}, 1, 1'b0, "add_ovf");
    run_op(32'h0FFF, 32'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h1000}, 0, 1'b0, "add_ripple");
  endtask

  task automatic test_sub();
    sel = 0;
    run_op(32'h0003, 32'h0005, 1'b0, 1'b1, {1'b0, 1'b1, 32'hFFFE}, 0, 1'b0, "sub_borrow");
    run_op(32'h8000, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b0, 32'h7FFF}, 2, 1'b0, "sub_ovf");
    run_op(32'h0005, 32'h0005, 1'b1, 1'b1, {1'b0, 1'b1, 32'hFFFF}, 0, 1'b0, "sub_bin");
  endtask

  task automatic test_backpressure();
    sel = 0;
    run_op(32'h1234, 32'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 32'h5555}, 3, 1'b1, "backpressure");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_idle%0d: got v=%b r=%b, required v=0 r=1", i, obs_out_valid,
                 obs_in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    sel = 0;
    run_op(32'hA5A5, 32'h0101, 1'b0, 1'b0, {1'b0, 1'b0, 32'hA6A6}, 0, 1'b0, "pre_reset");
    drv_a = 32'h8000; drv_b = 32'h8000; drv_cin = 1'b1; drv_sub = 1'b0;
    drv_in_valid = 1'b1;
    @(negedge clk);
    drv_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_sum !== 32'd0 ||
        obs_cout !== 1'b0 || obs_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got r=%b v=%b sum=%h c=%b o=%b, required 1 0 0 0 0",
               obs_in_ready, obs_out_valid, obs_sum, obs_cout, obs_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(nchunk_of(0)) + 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset%0d: got v=%b r=%b, required v=0 r=1", i, obs_out_valid,
                 obs_in_ready);
      end
    end
    run_op(32'hFFFF, 32'hFFFF, 1'b1, 1'b0, {1'b0, 1'b1, 32'hFFFF}, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random(input int unsigned s, input int count);
    logic [31:0] a, b;
    logic        cin, sub;
    int          stall;
    sel = s;
    @(negedge clk);
    for (int i = 0; i < count; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      sub = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '1;
        2: a = '0;
        3: b = '0;
        default: ;
      endcase
      stall = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      run_op(a, b, cin, sub, model(width_of(s), a, b, cin, sub), stall, 1'b1,
             $sformatf("rand_w%0d_%0d", width_of(s), i));
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    sel           = 0;
    drv_a         = '0;
    drv_b         = '0;
    drv_cin       = 1'b0;
    drv_sub       = 1'b0;
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    test_random(0, 1000);
    test_random(1, 1000);
    test_random(2, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks,
             errors);
    $fatal(1, "watchdog expired");
  end

endmodule
